// File: rtl/admin_pkg.sv
// Shared definitions for the administrator password entry path:
// digit-buffer geometry, FSM state type and nibble-position helper.
package admin_pkg;

  localparam int unsigned PW_DIGITS = 5;
  localparam int unsigned DIGIT_MAX = 9;
  localparam int unsigned PW_BITS   = 4 * PW_DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    LOCKED = 2'd2
  } pw_state_t;

  // LSB position of digit slot idx; slot 0 sits in the top nibble.
  function automatic logic [4:0] nibble_lsb(input logic [2:0] idx);
    return 5'(PW_BITS - 4 - 4 * int'(idx));
  endfunction

endpackage

// File: rtl/lockout_timer.sv
// Lockout countdown: loaded on start, done is high during the last
// counted cycle so the owner leaves lockout after exactly LOCK_CYCLES.
module lockout_timer #(
  parameter int unsigned LOCK_CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int unsigned CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(LOCK_CYCLES - 1);

  logic [CW-1:0] count;
  logic          running;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      count   <= LOAD;
      running <= 1'b1;
      done    <= (LOCK_CYCLES == 1);
    end else if (running) begin
      if (count != '0) begin
        count <= count - CW'(1);
        done  <= (count == CW'(1));
      end else begin
        running <= 1'b0;
        done    <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/admin_password_entry.sv
// Collects up to five key digits, checks them against the stored password
// on confirm, counts consecutive failures and enforces a timed lockout.
module admin_password_entry
  import admin_pkg::*;
#(
  parameter logic [19:0] PASSWORD    = 20'h12345,
  parameter int unsigned MAX_ERR     = 3,
  parameter int unsigned LOCK_CYCLES = 500_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        key_back,
  input  logic        key_confirm,
  output logic [19:0] ps_write,
  output logic [2:0]  cnt_ps,
  output logic [2:0]  ps_error_time,
  output logic        auth_ok,
  output logic        locked
);

  pw_state_t   state, state_nxt;
  logic [19:0] ps_write_nxt;
  logic [2:0]  cnt_nxt;
  logic [2:0]  err_nxt;
  logic [2:0]  err_inc;
  logic        auth_nxt;
  logic        locked_nxt;
  logic        lock_start;
  logic        lock_done;
  logic        pw_match;

  lockout_timer #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lockout_timer (
    .clk  (clk),
    .rst  (rst),
    .start(lock_start),
    .done (lock_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ps_write      <= '0;
      cnt_ps        <= '0;
      ps_error_time <= '0;
      auth_ok       <= 1'b0;
      locked        <= 1'b0;
    end else begin
      state         <= state_nxt;
      ps_write      <= ps_write_nxt;
      cnt_ps        <= cnt_nxt;
      ps_error_time <= err_nxt;
      auth_ok       <= auth_nxt;
      locked        <= locked_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ps_write_nxt = ps_write;
    cnt_nxt      = cnt_ps;
    err_nxt      = ps_error_time;
    auth_nxt     = 1'b0;
    locked_nxt   = locked;
    lock_start   = 1'b0;
    pw_match     = (cnt_ps == 3'(PW_DIGITS)) && (ps_write == PASSWORD);
    err_inc      = (ps_error_time >= 3'(MAX_ERR)) ? 3'(MAX_ERR)
                                                  : ps_error_time + 3'd1;

    case (state)
      IDLE: begin
        ps_write_nxt = '0;
        cnt_nxt      = '0;
        if (enable) state_nxt = ENTRY;
      end

      ENTRY: begin
        if (!enable) begin
          state_nxt    = IDLE;
          ps_write_nxt = '0;
          cnt_nxt      = '0;
        end else if (key_confirm) begin
          ps_write_nxt = '0;
          cnt_nxt      = '0;
          if (pw_match) begin
            auth_nxt = 1'b1;
            err_nxt  = '0;
          end else begin
            err_nxt = err_inc;
            if (err_inc == 3'(MAX_ERR)) begin
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
              lock_start = 1'b1;
            end
          end
        end else if (key_back) begin
          if (cnt_ps != 3'd0) begin
            cnt_nxt = cnt_ps - 3'd1;
            ps_write_nxt[nibble_lsb(cnt_ps - 3'd1) +: 4] = 4'd0;
          end
        end else if (key_valid && (key_code <= 4'(DIGIT_MAX))
                     && (cnt_ps < 3'(PW_DIGITS))) begin
          ps_write_nxt[nibble_lsb(cnt_ps) +: 4] = key_code;
          cnt_nxt = cnt_ps + 3'd1;
        end
      end

      LOCKED: begin
        // Keys and enable are ignored until the countdown expires.
        if (lock_done) begin
          locked_nxt = 1'b0;
          err_nxt    = '0;
          state_nxt  = enable ? ENTRY : IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_admin_password_entry.sv
// Self-checking bench for admin_password_entry: directed vector table,
// hand-written lockout/reset sequences and random traffic vs a digit-queue model.
module tb_admin_password_entry;

  localparam int unsigned MAX_ERR     = 3;
  localparam int unsigned LOCK_CYCLES = 8;
  localparam logic [19:0] PW          = 20'h12345;

  logic        clk = 1'b0;
  logic        rst, enable, key_valid, key_back, key_confirm;
  logic [3:0]  key_code;
  logic [19:0] ps_write;
  logic [2:0]  cnt_ps, ps_error_time;
  logic        auth_ok, locked;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  admin_password_entry #(
    .PASSWORD   (PW),
    .MAX_ERR    (MAX_ERR),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_back     (key_back),
    .key_confirm  (key_confirm),
    .ps_write     (ps_write),
    .cnt_ps       (cnt_ps),
    .ps_error_time(ps_error_time),
    .auth_ok      (auth_ok),
    .locked       (locked)
  );

  typedef struct {
    logic        r, en, kv;
    logic [3:0]  code;
    logic        bk, cf;
    logic [19:0] w;
    logic [2:0]  cnt, err;
    logic        auth, lck;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic en, logic kv, logic [3:0] code,
                              logic bk, logic cf, logic [19:0] w, logic [2:0] cnt,
                              logic [2:0] err, logic auth, logic lck);
    vec_t v;
    v.r = r; v.en = en; v.kv = kv; v.code = code; v.bk = bk; v.cf = cf;
    v.w = w; v.cnt = cnt; v.err = err; v.auth = auth; v.lck = lck;
    return v;
  endfunction

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic cyc(input logic r, input logic en, input logic kv,
                     input logic [3:0] code, input logic bk, input logic cf);
    rst = r; enable = en; key_valid = kv; key_code = code;
    key_back = bk; key_confirm = cf;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [19:0] w, input logic [2:0] cnt,
                       input logic [2:0] err, input logic auth, input logic lck);
    n_tests++;
    if (ps_write !== w || cnt_ps !== cnt || ps_error_time !== err ||
        auth_ok !== auth || locked !== lck) begin
      n_fail++;
      $display("FAIL %s: got w=%h cnt=%0d err=%0d auth=%b lock=%b, want w=%h cnt=%0d err=%0d auth=%b lock=%b",
               name, ps_write, cnt_ps, ps_error_time, auth_ok, locked,
               w, cnt, err, auth, lck);
    end
  endtask

  // Reference model: digits as a queue, lockout as cycles remaining.
  int  m_digits[$];
  int  m_err;
  int  m_lock_left;
  bit  m_active;
  bit  m_auth;

  function automatic logic [19:0] m_word();
    logic [19:0] w = '0;
    foreach (m_digits[i]) w = w | (20'(m_digits[i]) << (16 - 4 * i));
    return w;
  endfunction

  function automatic int pw_digit(int i);
    logic [19:0] p = PW;
    return int'((p >> (16 - 4 * i)) & 20'hF);
  endfunction

  task automatic m_step(input logic r, input logic en, input logic kv,
                        input logic [3:0] code, input logic bk, input logic cf);
    bit ok;
    m_auth = 0;
    if (r) begin
      m_digits.delete(); m_err = 0; m_lock_left = 0; m_active = 0;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) begin
        m_err = 0;
        m_active = en;
      end
    end else if (!m_active) begin
      m_digits.delete();
      m_active = en;
    end else if (!en) begin
      m_digits.delete();
      m_active = 0;
    end else if (cf) begin
      ok = (m_digits.size() == 5);
      for (int i = 0; i < m_digits.size(); i++)
        if (m_digits[i] != pw_digit(i)) ok = 0;
      m_digits.delete();
      if (ok) begin
        m_auth = 1;
        m_err = 0;
      end else begin
        m_err = (m_err + 1 > int'(MAX_ERR)) ? int'(MAX_ERR) : m_err + 1;
        if (m_err == int'(MAX_ERR)) m_lock_left = LOCK_CYCLES;
      end
    end else if (bk) begin
      if (m_digits.size() > 0) void'(m_digits.pop_back());
    end else if (kv && code <= 4'd9 && m_digits.size() < 5) begin
      m_digits.push_back(int'(code));
    end
  endtask

  initial begin
    // r en kv code bk cf | w cnt err auth lock
    vq.push_back(mk(1,0,0,0,0,0, 20'h00000,0,0,0,0));
    vq.push_back(mk(0,1,0,0,0,0, 20'h00000,0,0,0,0));
    vq.push_back(mk(0,1,1,1,0,0, 20'h10000,1,0,0,0));
    vq.push_back(mk(0,1,1,2,0,0, 20'h12000,2,0,0,0));
    vq.push_back(mk(0,1,1,3,0,0, 20'h12300,3,0,0,0));
    vq.push_back(mk(0,1,1,4,0,0, 20'h12340,4,0,0,0));
    vq.push_back(mk(0,1,1,5,0,0, 20'h12345,5,0,0,0));
    vq.push_back(mk(0,1,0,0,0,1, 20'h00000,0,0,1,0));
    vq.push_back(mk(0,1,0,0,0,0, 20'h00000,0,0,0,0));
    vq.push_back(mk(0,1,1,1,0,0, 20'h10000,1,0,0,0));
    vq.push_back(mk(0,1,1,2,0,0, 20'h12000,2,0,0,0));
    vq.push_back(mk(0,1,1,3,0,0, 20'h12300,3,0,0,0));
    vq.push_back(mk(0,1,0,0,1,0, 20'h12000,2,0,0,0));
    vq.push_back(mk(0,1,1,9,0,0, 20'h12900,3,0,0,0));
    vq.push_back(mk(0,1,0,0,1,0, 20'h12000,2,0,0,0));
    vq.push_back(mk(0,1,0,0,1,0, 20'h10000,1,0,0,0));
    vq.push_back(mk(0,1,0,0,1,0, 20'h00000,0,0,0,0));
    vq.push_back(mk(0,1,0,0,1,0, 20'h00000,0,0,0,0));
    vq.push_back(mk(0,1,1,1,0,0, 20'h10000,1,0,0,0));
    vq.push_back(mk(0,1,1,2,0,0, 20'h12000,2,0,0,0));
    vq.push_back(mk(0,1,1,3,0,0, 20'h12300,3,0,0,0));
    vq.push_back(mk(0,1,1,4,0,0, 20'h12340,4,0,0,0));
    vq.push_back(mk(0,1,1,5,0,0, 20'h12345,5,0,0,0));
    vq.push_back(mk(0,1,1,6,0,0, 20'h12345,5,0,0,0));
    vq.push_back(mk(0,1,1,12,0,0,20'h12345,5,0,0,0));
    vq.push_back(mk(0,1,0,0,1,0, 20'h12340,4,0,0,0));
    vq.push_back(mk(0,1,1,7,0,1, 20'h00000,0,1,0,0));
    vq.push_back(mk(0,1,0,0,0,0, 20'h00000,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0, 20'h00000,0,1,0,0));
    vq.push_back(mk(0,1,0,0,0,0, 20'h00000,0,1,0,0));
    vq.push_back(mk(0,1,1,8,0,0, 20'h80000,1,1,0,0));

    rst = 1; enable = 0; key_valid = 0; key_code = 0; key_back = 0; key_confirm = 0;
    @(negedge clk);

    foreach (vq[i]) begin
      cyc(vq[i].r, vq[i].en, vq[i].kv, vq[i].code, vq[i].bk, vq[i].cf);
      check($sformatf("vec%0d", i), vq[i].w, vq[i].cnt, vq[i].err, vq[i].auth, vq[i].lck);
    end

    // Dropping enable mid-entry clears the buffer but keeps the error count.
    cyc(0,1,1,1,0,0); cyc(0,1,1,2,0,0);
    check("entry3", 20'h81200, 3, 1, 0, 0);
    cyc(0,0,1,3,0,0);
    check("drop_en", 20'h00000, 0, 1, 0, 0);
    cyc(0,1,0,0,0,0);
    check("reenable", 20'h00000, 0, 1, 0, 0);

    // Lockout after three consecutive failures.
    cyc(1,0,0,0,0,0); check("rst2", 20'h0, 0, 0, 0, 0);
    cyc(0,1,0,0,0,0);
    for (int k = 0; k < 2; k++) begin
      for (int d = 5; d >= 1; d--) cyc(0,1,1,4'(d),0,0);
      check($sformatf("wrong%0d_full", k), 20'h54321, 5, 3'(k), 0, 0);
      cyc(0,1,0,0,0,1);
      check($sformatf("wrong%0d_cf", k), 20'h0, 0, 3'(k + 1), 0, 0);
    end
    cyc(0,1,1,1,0,0); cyc(0,1,1,2,0,0);
    cyc(0,1,0,0,0,1);
    check("lock_rise", 20'h0, 0, 3, 0, 1);
    for (int k = 1; k < int'(LOCK_CYCLES); k++) begin
      cyc(0, 1'($urandom), 1, 4'($urandom_range(0, 9)), 1'($urandom), 1'($urandom));
      check($sformatf("lock_hold%0d", k), 20'h0, 0, 3, 0, 1);
    end
    cyc(0,1,0,0,0,0);
    check("lock_fall", 20'h0, 0, 0, 0, 0);
    cyc(0,1,1,4,0,0);
    check("post_lock_digit", 20'h40000, 1, 0, 0, 0);

    // Reset in the middle of a lockout.
    cyc(0,1,0,0,0,1); cyc(0,1,0,0,0,1); cyc(0,1,0,0,0,1);
    check("lock2_rise", 20'h0, 0, 3, 0, 1);
    cyc(0,1,0,0,0,0); cyc(0,1,0,0,0,0);
    cyc(1,1,0,0,0,0);
    check("rst_in_lock", 20'h0, 0, 0, 0, 0);
    cyc(0,1,0,0,0,0);
    cyc(0,1,1,6,0,0);
    check("post_rst_digit", 20'h60000, 1, 0, 0, 0);
    for (int k = 0; k < int'(LOCK_CYCLES) + 2; k++) cyc(0,1,0,0,0,0);
    check("post_rst_unlocked", 20'h60000, 1, 0, 0, 0);

    // Random traffic against the model; half the digits follow the password.
    for (int i = 0; i < 3000; i++) begin
      logic r, en, kv, bk, cf;
      logic [3:0] code;
      r    = (i == 0) || ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 31) != 0);
      kv   = ($urandom_range(0, 1) == 0);
      bk   = ($urandom_range(0, 7) == 0);
      cf   = ($urandom_range(0, 9) == 0);
      code = ($urandom_range(0, 1) == 0 && m_digits.size() < 5)
             ? 4'(pw_digit(m_digits.size())) : 4'($urandom_range(0, 15));
      cyc(r, en, kv, code, bk, cf);
      m_step(r, en, kv, code, bk, cf);
      check($sformatf("rand%0d", i), m_word(), 3'(m_digits.size()), 3'(m_err),
            m_auth, (m_lock_left > 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/admin_password_entry.md
# admin_password_entry

Upstream stage of the administrator display path. It collects up to five decimal key digits and produces the `ps_write` / `cnt_ps` / `ps_error_time` values that the display renders in its password state. It compares the entry against a stored password on confirm, and pulses `auth_ok` so the administrator FSM can advance. It counts failed attempts and enforces a timed lockout after `MAX_ERR` consecutive failures.

## Interface
Parameters:
- `PASSWORD`, 20'h12345: stored password, five BCD nibbles, first digit in [19:16].
- `MAX_ERR`, 3: failed confirms that trigger lockout (1..7).
- `LOCK_CYCLES`, 500_000_000: lockout length in clk cycles (5 s at 100 MHz).

Ports:
- `clk`  in  1  system clock; the block uses one clock.
- `rst`  in  1  reset; synchronous and active-high.
- `enable`  in  1  high while the admin FSM is in its password state.
- `key_valid`  in  1  one-cycle pulse; `key_code` holds a digit.
- `key_code`  in  4  digit value; 0..9 accepted, 10..15 ignored.
- `key_back`  in  1  one-cycle pulse; delete the last digit.
- `key_confirm`  in  1  one-cycle pulse; submit the entry.
- `ps_write`  out  20  entered digits, first digit in [19:16], unentered nibbles 0.
- `cnt_ps`  out  3  digits entered, 0..5.
- `ps_error_time`  out  3  consecutive failed confirms, 0..`MAX_ERR`.
- `auth_ok`  out  1  one-cycle pulse on a correct confirm.
- `locked`  out  1  high during lockout.

## Operation
- States: IDLE, ENTRY, LOCKED. Reset enters IDLE.
- Reset values: `ps_write` 0, `cnt_ps` 0, `ps_error_time` 0, `auth_ok` 0, `locked` 0, lock counter 0.
- IDLE:
  - `ps_write` and `cnt_ps` are held at 0. `ps_error_time` is retained.
  - `enable`=1 moves the FSM to ENTRY.
- ENTRY, leaving the state: `enable`=0 moves to IDLE. The digit buffer clears in the same edge and any key pulse in that cycle is ignored.
- ENTRY, key priority per cycle: confirm, then back, then digit. Only one action executes per cycle.
- Digit action: requires `key_code`≤9 and `cnt_ps`<5. The nibble at bits [19-4·cnt_ps -: 4] is set to `key_code` and `cnt_ps` increments. A digit with `cnt_ps`=5 or `key_code`>9 changes nothing.
- Back action: requires `cnt_ps`>0. `cnt_ps` decrements and the nibble at the new index is cleared. With `cnt_ps`=0 it changes nothing.
- Confirm, match case (`cnt_ps`=5 and `ps_write`==`PASSWORD`):
  - `auth_ok`=1 for one cycle.
  - `ps_error_time` becomes 0.
  - The buffer clears and the FSM stays in ENTRY.
- Confirm, any other case (including a short entry):
  - The buffer clears.
  - `ps_error_time` increments, saturating at `MAX_ERR`.
  - If the new value equals `MAX_ERR`, the FSM moves to LOCKED, sets `locked`=1 and loads the lock counter with `LOCK_CYCLES`-1.
- LOCKED:
  - All key inputs and `enable` are ignored.
  - The counter decrements each cycle.
  - At counter 0 (after exactly `LOCK_CYCLES` cycles with `locked`=1): `locked`=0, `ps_error_time`=0, and the FSM moves to ENTRY if `enable`=1, else to IDLE.
- `rst` during any state, including LOCKED, returns everything to reset values on that edge.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- A digit or back pulse at edge N is reflected in `ps_write` and `cnt_ps` after edge N.
- For a confirm at edge N, `auth_ok` and the buffer clear are visible after edge N. On a lockout-triggering failure, `locked` also rises after edge N.
- `auth_ok` never asserts on two consecutive cycles.
- Key pulses are assumed already debounced and one cycle wide; a held-high `key_valid` enters one digit per cycle.

## Structure
- Shared package `admin_pkg`:
  - `PW_DIGITS`=5
  - `DIGIT_MAX`=9
  - the state enum `pw_state_t` {IDLE, ENTRY, LOCKED}
  - the nibble-index helper function
- Sub-module `lockout_timer`:
  - inputs: `clk`, `rst`, `start`
  - output: `done` pulse
  - counter width $clog2(`LOCK_CYCLES`)
  - instanced once.

## Test plan
All scenarios run with `LOCK_CYCLES`=8 and `MAX_ERR`=3.
- Reset, `enable`=1, digits 1,2,3,4,5, confirm → `cnt_ps` steps 1..5; `ps_write`=20'h12345; `auth_ok` is one cycle high; then `ps_write`=0, `cnt_ps`=0, `ps_error_time`=0.
- Digits 1,2,3, back, 9 → `ps_write`=20'h12900, `cnt_ps`=3. Back four times → `cnt_ps`=0, `ps_write`=0, with no underflow.
- Six digits 1..6, and a `key_code`=12 pulse → `ps_write`=20'h12345, `cnt_ps`=5; the sixth digit and code 12 are ignored.
- Wrong entry 5,4,3,2,1 confirm, twice → `ps_error_time`=2, `locked`=0. Third confirm of a 2-digit entry → `ps_error_time`=3 and `locked`=1 for exactly 8 cycles; keys during that window are ignored; afterwards `ps_error_time`=0 in ENTRY.
- Confirm and digit in the same cycle → only the confirm executes (error increments, buffer cleared, no digit stored). `rst` mid-lockout → `locked`=0 and all outputs 0 on the next cycle.
- Enter 3 digits then drop `enable` → IDLE with `ps_write`=0 and `cnt_ps`=0; `ps_error_time` is preserved across the IDLE/ENTRY round trip.
